// File: rtl/s3g_tx.sv
// S3G packet transmitter: frames START_BYTE, len, payload, CRC-8 into a byte UART.
// Optional WAIT timeout abort is enabled by defining S3G_TX_TIMEOUT_EN.
module s3g_tx #(
  parameter logic [7:0]  START_BYTE = 8'hD5,
  parameter logic [15:0] TIMEOUT    = 16'd65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] payload_len,
  output logic [7:0] buf_addr,
  input  logic [7:0] buf_data,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  input  logic       tx_done,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {IDLE, HDR, LEN, FETCH, DATA, CRC, WAIT} state_e;

  state_e     state_q, resume_q;
  logic [7:0] len_q, rem_q, crc_q, addr_q, txd_q;
  logic       wr_q, busy_q, done_q;
  logic [7:0] crc_d;

  // Reflected CRC-8 (x^8+x^5+x^4+1), LSB-first, one byte per call.
  function automatic logic [7:0] nextCRC8_D8(input logic [7:0] d, input logic [7:0] c);
    logic [7:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 8'h8C) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    crc_d = nextCRC8_D8(buf_data, crc_q);
  end

`ifdef S3G_TX_TIMEOUT_EN
  logic [15:0] tmo_q;
  logic        err_q;
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      resume_q <= IDLE;
      len_q    <= '0;
      rem_q    <= '0;
      crc_q    <= '0;
      addr_q   <= '0;
      txd_q    <= '0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef S3G_TX_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      wr_q   <= 1'b0;
      done_q <= 1'b0;
`ifdef S3G_TX_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (start) begin
            len_q   <= payload_len;
            rem_q   <= payload_len;
            crc_q   <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b1;
            wr_q    <= 1'b1;
            txd_q   <= START_BYTE;
            state_q <= HDR;
          end
        end
        HDR: begin
          resume_q <= LEN;
          state_q  <= WAIT;
`ifdef S3G_TX_TIMEOUT_EN
          tmo_q    <= '0;
`endif
        end
        LEN: begin
          resume_q <= (len_q != 8'd0) ? FETCH : CRC;
          state_q  <= WAIT;
`ifdef S3G_TX_TIMEOUT_EN
          tmo_q    <= '0;
`endif
        end
        FETCH: begin
          // buf_addr has been stable since before FETCH, so buf_data is current here.
          wr_q    <= 1'b1;
          txd_q   <= buf_data;
          crc_q   <= crc_d;
          rem_q   <= rem_q - 8'd1;
          state_q <= DATA;
        end
        DATA: begin
          // Advance the address while waiting so the next FETCH sees valid read data.
          if (rem_q != 8'd0) begin
            addr_q   <= addr_q + 8'd1;
            resume_q <= FETCH;
          end else begin
            resume_q <= CRC;
          end
          state_q <= WAIT;
`ifdef S3G_TX_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        CRC: begin
          resume_q <= IDLE;
          state_q  <= WAIT;
`ifdef S3G_TX_TIMEOUT_EN
          tmo_q    <= '0;
`endif
        end
        WAIT: begin
          if (tx_done) begin
            unique case (resume_q)
              LEN: begin
                state_q <= LEN;
                wr_q    <= 1'b1;
                txd_q   <= len_q;
              end
              FETCH: state_q <= FETCH;
              CRC: begin
                state_q <= CRC;
                wr_q    <= 1'b1;
                txd_q   <= crc_q;
              end
              default: begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            endcase
          end
`ifdef S3G_TX_TIMEOUT_EN
          else if (tmo_q == TIMEOUT - 16'd1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign buf_addr = addr_q;
  assign tx_data  = txd_q;
  assign tx_wr    = wr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_s3g_tx.sv
// Bench for s3g_tx: frame-level reference model checked every cycle plus literal frame checks.
// Timeout scenario runs only when S3G_TX_TIMEOUT_EN is defined.
module tb_s3g_tx;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst, start, tx_done;
  logic [7:0] payload_len, buf_data, buf_addr, tx_data;
  logic       tx_wr, busy, done, error;

  always #5 clk = ~clk;

`ifdef S3G_TX_TIMEOUT_EN
  s3g_tx #(.START_BYTE(8'hD5), .TIMEOUT(16'(TMO))) dut (
`else
  s3g_tx #(.START_BYTE(8'hD5)) dut (
`endif
    .clk(clk), .rst(rst), .start(start), .payload_len(payload_len),
    .buf_addr(buf_addr), .buf_data(buf_data), .tx_data(tx_data), .tx_wr(tx_wr),
    .tx_done(tx_done), .busy(busy), .done(done), .error(error)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         mon_on = 0;
  logic [7:0] mem [256];
  int         resp_dly = 10;
  bit         resp_en = 1;
  bit         dbl = 0;
  int         inj_req = 0;
  logic [7:0] cap [$];
  int         n_done = 0, n_err = 0, last_wr_obs = 0, err_cyc = 0;

  // reference model state (frame level)
  bit         m_busy = 0, m_await = 0;
  int         m_next_wr = -1, m_last_wr = -1, m_pos = 0, m_len = 0;
  logic [7:0] m_frame [$];
  logic [7:0] m_txd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r, d;
    r = c;
    d = b;
    for (int i = 0; i < 8; i++) begin
      if ((r[0] ^ d[0]) == 1'b1) r = (r >> 1) ^ 8'h8C;
      else r = r >> 1;
      d = d >> 1;
    end
    return r;
  endfunction

  // Synchronous buffer: data for an address appears one cycle later.
  initial begin
    logic [7:0] a_prev;
    a_prev = '0;
    buf_data = '0;
    forever begin
      @(negedge clk);
      buf_data = mem[a_prev];
      a_prev = buf_addr;
    end
  end

  // UART responder: tx_done resp_dly cycles after each tx_wr, optional doubled pulse.
  initial begin
    int pend, seen;
    bit extra;
    pend = 0; seen = 0; extra = 0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (extra) begin tx_done = 1'b1; extra = 0; end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin tx_done = 1'b1; extra = dbl; end
      end
      if (inj_req != seen) begin tx_done = 1'b1; seen = inj_req; end
      if (tx_wr === 1'b1 && resp_en) pend = resp_dly;
    end
  end

  // Inputs seen here are those sampled at the edge just passed; outputs are this cycle's.
  task automatic step();
    bit e_wr, e_done, e_err, was_busy, hit;
    logic [7:0] c;
    int lim;
    e_wr = 0; e_done = 0; e_err = 0; hit = 0;
    if (rst !== 1'b1) begin
      m_busy = 0; m_await = 0; m_next_wr = -1; m_txd = '0; m_len = 0;
      chk("rst_buf_addr", 32'(buf_addr), 0);
    end else begin
      was_busy = m_busy;
      if (tx_done === 1'b1 && m_await && (cyc - 1) > m_last_wr) begin
        m_await = 0; hit = 1;
        if (m_pos == m_frame.size()) begin e_done = 1; m_busy = 0; end
        else if (m_pos >= 2 && m_pos < m_frame.size() - 1) m_next_wr = cyc + 1;
        else m_next_wr = cyc;
      end
`ifdef S3G_TX_TIMEOUT_EN
      if (!hit && m_await && (cyc - 1 - m_last_wr) == TMO) begin
        m_await = 0; m_busy = 0; e_err = 1;
      end
`endif
      if (start === 1'b1 && !was_busy) begin
        m_len = int'(payload_len);
        m_frame = {};
        m_frame.push_back(8'hD5);
        m_frame.push_back(payload_len);
        c = '0;
        for (int i = 0; i < m_len; i++) begin
          m_frame.push_back(mem[i]);
          c = crc_upd(c, mem[i]);
        end
        m_frame.push_back(c);
        m_busy = 1; m_pos = 0; m_next_wr = cyc;
      end
      if (m_next_wr == cyc) begin
        e_wr = 1; m_txd = m_frame[m_pos]; m_pos++;
        m_last_wr = cyc; m_await = 1; m_next_wr = -1;
      end
      if (m_busy && m_next_wr == cyc + 1) chk("fetch_addr", 32'(buf_addr), 32'(m_pos - 2));
      if (m_busy) begin
        lim = (m_len == 0) ? 0 : m_len - 1;
        chk("addr_range", 32'(int'(buf_addr) <= lim), 1);
      end
    end
    chk("tx_wr", 32'(tx_wr), 32'(e_wr));
    chk("done", 32'(done), 32'(e_done));
    chk("error", 32'(error), 32'(e_err));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("tx_data", 32'(tx_data), 32'(m_txd));
    if (tx_wr === 1'b1) begin cap.push_back(tx_data); last_wr_obs = cyc; end
    if (done === 1'b1) n_done++;
    if (error === 1'b1) begin n_err++; err_cyc = cyc; end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mon_on) step();
    end
  end

  task automatic send(input logic [7:0] len);
    @(negedge clk);
    payload_len = len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit);
    int k;
    k = 0;
    while (n_done == base && k < limit) begin @(negedge clk); k++; end
    chk("done_count", 32'(n_done - base), 1);
  endtask

  task automatic chk_cap(input string nm, input int base, input logic [7:0] exp[$]);
    chk({nm, "_nbytes"}, 32'(cap.size() - base), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (base + i < cap.size()) chk({nm, "_byte"}, 32'(cap[base + i]), 32'(exp[i]));
  endtask

  initial begin
    logic [7:0] e [$];
    logic [7:0] c;
    int b, bd, k;
    rst = 1'b0; start = 1'b0; payload_len = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    mon_on = 1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_wr", 32'(tx_wr), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // single-byte packet, slow UART
    mem[0] = 8'h01; resp_dly = 10;
    b = cap.size(); bd = n_done;
    send(8'd1);
    wait_done(bd, 300);
    e = {8'hD5, 8'h01, 8'h01, 8'h5E};
    chk_cap("len1", b, e);
    @(negedge clk);
    chk("len1_busy_after", 32'(busy), 0);

    // empty payload
    resp_dly = 4; b = cap.size(); bd = n_done;
    send(8'd0);
    wait_done(bd, 200);
    e = {8'hD5, 8'h00, 8'h00};
    chk_cap("len0", b, e);

    // second start while busy is ignored
    mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC; resp_dly = 3;
    b = cap.size(); bd = n_done;
    send(8'd3);
    repeat (6) @(negedge clk);
    send(8'd7);
    wait_done(bd, 300);
    repeat (40) @(negedge clk);
    chk("len3_single_done", 32'(n_done - bd), 1);
    c = crc_upd(crc_upd(crc_upd(8'h00, 8'hAA), 8'hBB), 8'hCC);
    e = {8'hD5, 8'h03, 8'hAA, 8'hBB, 8'hCC, c};
    chk_cap("len3", b, e);

    // reset mid-frame, then a fresh frame
    for (int i = 0; i < 5; i++) mem[i] = 8'(8'h11 * (i + 1));
    resp_dly = 2; b = cap.size(); bd = n_done;
    send(8'd5);
    k = 0;
    while (cap.size() - b < 4 && k < 200) begin @(negedge clk); k++; end
    chk("rst_mid_reached", 32'(cap.size() - b), 4);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 0);
    repeat (20) @(negedge clk);
    chk("rst_mid_no_done", 32'(n_done - bd), 0);
    b = cap.size(); bd = n_done;
    send(8'd5);
    wait_done(bd, 300);
    c = 8'h00;
    for (int i = 0; i < 5; i++) c = crc_upd(c, mem[i]);
    e = {8'hD5, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, c};
    chk_cap("fresh5", b, e);

    // stray tx_done in IDLE, then doubled pulses landing in FETCH/LEN/IDLE
    b = cap.size();
    inj_req++;
    repeat (5) @(negedge clk);
    chk("idle_inj_busy", 32'(busy), 0);
    chk("idle_inj_no_wr", 32'(cap.size() - b), 0);
    mem[0] = 8'h3C; mem[1] = 8'hC3; dbl = 1; resp_dly = 2;
    b = cap.size(); bd = n_done;
    send(8'd2);
    wait_done(bd, 300);
    repeat (4) @(negedge clk);
    dbl = 0;
    c = crc_upd(crc_upd(8'h00, 8'h3C), 8'hC3);
    e = {8'hD5, 8'h02, 8'h3C, 8'hC3, c};
    chk_cap("dbl", b, e);

    // new start accepted in the done cycle
    mem[0] = 8'h01; resp_dly = 3;
    b = cap.size(); bd = n_done;
    send(8'd1);
    k = 0;
    while (done !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    chk("b2b_done_seen", 32'(done), 1);
    payload_len = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(bd + 1, 200);
    e = {8'hD5, 8'h01, 8'h01, 8'h5E, 8'hD5, 8'h00, 8'h00};
    chk_cap("b2b", b, e);

    // maximum length
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    resp_dly = 1; b = cap.size(); bd = n_done;
    send(8'd255);
    wait_done(bd, 4000);
    chk("len255_nbytes", 32'(cap.size() - b), 258);
    if (cap.size() - b == 258) begin
      chk("len255_len", 32'(cap[b + 1]), 32'h0FF);
      chk("len255_last", 32'(cap[b + 256]), 32'(8'd254 ^ 8'h5A));
    end

`ifdef S3G_TX_TIMEOUT_EN
    resp_en = 0; bd = n_done; k = n_err;
    send(8'd2);
    begin
      int w;
      w = 0;
      while (n_err == k && w < 200) begin @(negedge clk); w++; end
    end
    chk("tmo_error_count", 32'(n_err - k), 1);
    chk("tmo_latency", 32'(err_cyc - last_wr_obs), 17);
    chk("tmo_no_done", 32'(n_done - bd), 0);
    chk("tmo_busy", 32'(busy), 0);
    resp_en = 1;
    repeat (5) @(negedge clk);
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
